// File: rtl/dense_layer_sequencer_pkg.sv
// Shared types, constants and helper functions for the dense layer sequencer.
package dense_layer_sequencer_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned PROD_W     = 16;
  localparam int unsigned IN_SIZE_1  = 4;
  localparam int unsigned OUT_SIZE_1 = 2;
  localparam int unsigned ACC_W_1    = 24;
  localparam int unsigned SAT_W      = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BIAS  = 3'd1,
    MAC   = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  // Address width for a memory of n entries; a single entry still needs one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_int8(input logic signed [SAT_W-1:0] x);
    if (x > 127)       return 8'sh7f;
    else if (x < -128) return 8'sh80;
    else               return x[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/dense_layer_sequencer_if.sv
// Control, memory-read and output-write signals between the sequencer and its buffers.
interface dense_layer_sequencer_if
  import dense_layer_sequencer_pkg::*;
#(
  parameter int unsigned IN_SIZE  = IN_SIZE_1,
  parameter int unsigned OUT_SIZE = OUT_SIZE_1
);
  localparam int unsigned IN_AW  = addr_w(IN_SIZE);
  localparam int unsigned OUT_AW = addr_w(OUT_SIZE);
  localparam int unsigned W_AW   = addr_w(IN_SIZE * OUT_SIZE);

  logic                     start;
  logic                     busy;
  logic                     done;
  logic [IN_AW-1:0]         in_addr;
  logic signed [DATA_W-1:0] in_data;
  logic [W_AW-1:0]          w_addr;
  logic signed [DATA_W-1:0] w_data;
  logic [OUT_AW-1:0]        b_addr;
  logic signed [DATA_W-1:0] b_data;
  logic                     out_we;
  logic [OUT_AW-1:0]        out_addr;
  logic signed [DATA_W-1:0] out_data;

  modport master (
    input  start, in_data, w_data, b_data,
    output busy, done, in_addr, w_addr, b_addr, out_we, out_addr, out_data
  );

  modport slave (
    output start, in_data, w_data, b_data,
    input  busy, done, in_addr, w_addr, b_addr, out_we, out_addr, out_data
  );

endinterface

// File: rtl/dense_mac_unit.sv
// Full-width MAC accumulator plus int8 conversion and ReLU output register.
// DENSE_SEQ_SAT_EN selects saturating conversion; otherwise the low byte wraps.
module dense_mac_unit
  import dense_layer_sequencer_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_load_bias,
  input  logic                     i_acc_en,
  input  logic signed [DATA_W-1:0] i_bias,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [DATA_W-1:0] i_w,
  output logic signed [DATA_W-1:0] o_result
);

  logic signed [ACC_W-1:0]  r_acc;
  logic signed [DATA_W-1:0] r_result;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_acc_base;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic signed [DATA_W-1:0] w_conv;
  logic signed [DATA_W-1:0] w_relu;

  // Result is computed from the next accumulator value so it is ready in the WRITE cycle.
  always_comb begin
    w_prod     = i_x * i_w;
    w_acc_base = i_load_bias ? ACC_W'(i_bias) : r_acc;
    w_acc_nxt  = w_acc_base + ACC_W'(w_prod);
`ifdef DENSE_SEQ_SAT_EN
    w_conv     = sat_int8(SAT_W'(w_acc_nxt));
`else
    w_conv     = w_acc_nxt[DATA_W-1:0];
`endif
    w_relu     = w_conv[DATA_W-1] ? '0 : w_conv;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_result <= '0;
    end else if (i_clear) begin
      r_acc    <= '0;
    end else if (i_acc_en) begin
      r_acc    <= w_acc_nxt;
      r_result <= w_relu;
    end
  end

  assign o_result = r_result;

endmodule

// File: rtl/dense_layer_sequencer.sv
// Time-multiplexed fully-connected layer: walks neurons and inputs through one MAC
// and writes one ReLU'd int8 result per neuron.
module dense_layer_sequencer
  import dense_layer_sequencer_pkg::*;
#(
  parameter int unsigned IN_SIZE  = IN_SIZE_1,
  parameter int unsigned OUT_SIZE = OUT_SIZE_1,
  parameter int unsigned ACC_W    = ACC_W_1
) (
  input logic                     clk,
  input logic                     rst,
  dense_layer_sequencer_if.master bus
);

  localparam int unsigned IN_AW  = addr_w(IN_SIZE);
  localparam int unsigned OUT_AW = addr_w(OUT_SIZE);
  localparam int unsigned W_AW   = addr_w(IN_SIZE * OUT_SIZE);
  localparam logic [IN_AW-1:0]  J_LAST   = IN_AW'(IN_SIZE - 1);
  localparam logic [OUT_AW-1:0] I_LAST   = OUT_AW'(OUT_SIZE - 1);
  localparam bit                MULTI_IN = (IN_SIZE > 1);

  seq_state_t         r_state, w_state_nxt;
  logic [OUT_AW-1:0]  r_i, w_i_nxt;
  logic [IN_AW-1:0]   r_j, w_j_nxt;
  logic [IN_AW-1:0]   r_in_addr, w_in_addr_nxt;
  logic [W_AW-1:0]    r_w_addr, w_w_addr_nxt;
  logic [OUT_AW-1:0]  r_b_addr, w_b_addr_nxt;
  logic [OUT_AW-1:0]  r_out_addr, w_out_addr_nxt;
  logic               r_busy, r_done, r_out_we;
  logic               w_clear, w_load_bias, w_acc_en;
  logic signed [DATA_W-1:0] w_result;

  // Next-state, counter and address logic; addresses run one index ahead of the MAC.
  always_comb begin
    w_state_nxt    = r_state;
    w_i_nxt        = r_i;
    w_j_nxt        = r_j;
    w_in_addr_nxt  = r_in_addr;
    w_w_addr_nxt   = r_w_addr;
    w_b_addr_nxt   = r_b_addr;
    w_out_addr_nxt = r_out_addr;
    w_clear        = 1'b0;
    w_load_bias    = 1'b0;
    w_acc_en       = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt   = BIAS;
          w_i_nxt       = '0;
          w_j_nxt       = '0;
          w_in_addr_nxt = '0;
          w_w_addr_nxt  = '0;
          w_b_addr_nxt  = '0;
          w_clear       = 1'b1;
        end
      end
      BIAS: begin
        w_state_nxt = MAC;
        w_j_nxt     = '0;
        if (MULTI_IN) begin
          w_in_addr_nxt = r_in_addr + IN_AW'(1);
          w_w_addr_nxt  = r_w_addr + W_AW'(1);
        end
      end
      MAC: begin
        w_acc_en    = 1'b1;
        w_load_bias = (r_j == '0);
        if (r_j == J_LAST) begin
          w_state_nxt    = WRITE;
          w_out_addr_nxt = r_i;
        end else begin
          w_j_nxt = r_j + IN_AW'(1);
          if (r_j + IN_AW'(1) != J_LAST) begin
            w_in_addr_nxt = r_in_addr + IN_AW'(1);
            w_w_addr_nxt  = r_w_addr + W_AW'(1);
          end
        end
      end
      WRITE: begin
        if (r_i == I_LAST) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt   = BIAS;
          w_i_nxt       = r_i + OUT_AW'(1);
          w_j_nxt       = '0;
          w_b_addr_nxt  = r_i + OUT_AW'(1);
          w_in_addr_nxt = '0;
          w_w_addr_nxt  = r_w_addr + W_AW'(1);
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_i        <= '0;
      r_j        <= '0;
      r_in_addr  <= '0;
      r_w_addr   <= '0;
      r_b_addr   <= '0;
      r_out_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_out_we   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_i        <= w_i_nxt;
      r_j        <= w_j_nxt;
      r_in_addr  <= w_in_addr_nxt;
      r_w_addr   <= w_w_addr_nxt;
      r_b_addr   <= w_b_addr_nxt;
      r_out_addr <= w_out_addr_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_done     <= (w_state_nxt == DONE);
      r_out_we   <= (w_state_nxt == WRITE);
    end
  end

  dense_mac_unit #(.ACC_W(ACC_W)) u_mac (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_load_bias (w_load_bias),
    .i_acc_en    (w_acc_en),
    .i_bias      (bus.b_data),
    .i_x         (bus.in_data),
    .i_w         (bus.w_data),
    .o_result    (w_result)
  );

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.in_addr  = r_in_addr;
  assign bus.w_addr   = r_w_addr;
  assign bus.b_addr   = r_b_addr;
  assign bus.out_we   = r_out_we;
  assign bus.out_addr = r_out_addr;
  assign bus.out_data = w_result;

endmodule
